// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, loader and data-memory signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_lock;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  l_req, l_we, l_addr, l_wdata, l_lock,
        output l_gnt, l_rvalid, l_rdata,
        output mem_we, mem_a, mem_d,
        input  mem_q
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output l_req, l_we, l_addr, l_wdata, l_lock,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_we, mem_a, mem_d,
        output mem_q
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between CPU and loader
// CPU has priority; loader wins after MAX_WAIT starved cycles or while holding a burst lock.
module dmem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic {
        OPEN,
        LOCKED
    } state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] a_hold;
    logic              c_rvalid_q;
    logic              l_rvalid_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] l_rdata_q;

    logic              starved;
    logic              c_gnt;
    logic              l_gnt;

    always_comb begin
        starved = (wait_cnt == WAIT_LIMIT);
        c_gnt   = !rst && (state == OPEN) && bus.c_req && !(bus.l_req && starved);
        l_gnt   = !rst && bus.l_req && ((state == LOCKED) || !bus.c_req || starved);
    end

    // Idle cycles keep the last address on the bus so the memory sees no spurious toggling.
    always_comb begin
        bus.mem_we = 1'b0;
        bus.mem_a  = a_hold;
        bus.mem_d  = '0;
        if (c_gnt) begin
            bus.mem_we = bus.c_we;
            bus.mem_a  = bus.c_addr;
            bus.mem_d  = bus.c_wdata;
        end else if (l_gnt) begin
            bus.mem_we = bus.l_we;
            bus.mem_a  = bus.l_addr;
            bus.mem_d  = bus.l_wdata;
        end
    end

    always_comb begin
        bus.c_gnt    = c_gnt;
        bus.l_gnt    = l_gnt;
        bus.c_rvalid = c_rvalid_q;
        bus.l_rvalid = l_rvalid_q;
        bus.c_rdata  = c_rdata_q;
        bus.l_rdata  = l_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OPEN;
            wait_cnt   <= 4'd0;
            a_hold     <= '0;
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            if (c_gnt || l_gnt) begin
                a_hold <= bus.mem_a;
            end

            if (l_gnt) begin
                wait_cnt <= 4'd0;
            end else if (bus.l_req && (wait_cnt < WAIT_LIMIT)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            // The unlocking cycle itself still belongs to the loader.
            case (state)
                OPEN:    if (l_gnt && bus.l_lock) state <= LOCKED;
                LOCKED:  if (!bus.l_lock)         state <= OPEN;
                default:                          state <= OPEN;
            endcase

            c_rvalid_q <= c_gnt && !bus.c_we;
            l_rvalid_q <= l_gnt && !bus.l_we;
            if (c_gnt && !bus.c_we) begin
                c_rdata_q <= bus.mem_q;
            end
            if (l_gnt && !bus.l_we) begin
                l_rdata_q <= bus.mem_q;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - cycle-vector bench for dmem_arbiter with read-data scoreboard
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        cr;
        logic        cw;
        logic [5:0]  ca;
        logic [31:0] cd;
        logic        lr;
        logic        lw;
        logic [5:0]  la;
        logic [31:0] ld;
        logic        lk;
        logic        ecg;
        logic        elg;
    } vec_t;

    function automatic logic [31:0] init_val(int i);
        if (i == 9) return 32'h1111_1111;
        return {8'(i), 24'h5A_3C_00};
    endfunction

    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_a] <= bus.mem_d;
        end
    end
    assign bus.mem_q = mem[bus.mem_a];

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] cq[$];
    logic [31:0] lq[$];
    logic        pend_c;
    logic        pend_l;
    logic [31:0] exp_crdata;
    logic [31:0] exp_lrdata;
    logic [5:0]  hold_a;
    vec_t        tbl[$];

    function automatic vec_t mk(logic r, logic cr, logic cw, logic [5:0] ca, logic [31:0] cd,
                                logic lr, logic lw, logic [5:0] la, logic [31:0] ld, logic lk,
                                logic ecg, logic elg);
        vec_t v;
        v.rst = r;  v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.lr = lr;  v.lw = lw; v.la = la; v.ld = ld; v.lk = lk;
        v.ecg = ecg; v.elg = elg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        logic        ewe;
        logic [5:0]  ea;
        logic [31:0] ed;
        rst         = v.rst;
        bus.c_req   = v.cr;  bus.c_we = v.cw; bus.c_addr = v.ca; bus.c_wdata = v.cd;
        bus.l_req   = v.lr;  bus.l_we = v.lw; bus.l_addr = v.la; bus.l_wdata = v.ld;
        bus.l_lock  = v.lk;
        ewe = (v.ecg && v.cw) || (v.elg && v.lw);
        ea  = v.ecg ? v.ca : (v.elg ? v.la : hold_a);
        ed  = v.ecg ? v.cd : (v.elg ? v.ld : 32'h0);
        @(negedge clk);
        chk("c_gnt", 32'(bus.c_gnt), 32'(v.ecg));
        chk("l_gnt", 32'(bus.l_gnt), 32'(v.elg));
        chk("mem_we", 32'(bus.mem_we), 32'(ewe));
        chk("mem_a", 32'(bus.mem_a), 32'(ea));
        chk("mem_d", bus.mem_d, ed);
        chk("c_rvalid", 32'(bus.c_rvalid), 32'(pend_c));
        chk("l_rvalid", 32'(bus.l_rvalid), 32'(pend_l));
        if (pend_c) begin
            if (cq.size() == 0) chk("c_queue", 32'd0, 32'd1);
            else exp_crdata = cq.pop_front();
        end
        if (pend_l) begin
            if (lq.size() == 0) chk("l_queue", 32'd0, 32'd1);
            else exp_lrdata = lq.pop_front();
        end
        chk("c_rdata", bus.c_rdata, exp_crdata);
        chk("l_rdata", bus.l_rdata, exp_lrdata);
        if (v.rst) begin
            pend_c = 1'b0;  pend_l = 1'b0;
            exp_crdata = '0; exp_lrdata = '0;
            hold_a = '0;
        end else begin
            pend_c = v.ecg && !v.cw;
            pend_l = v.elg && !v.lw;
            if (pend_c) cq.push_back(ref_mem[v.ca]);
            if (pend_l) lq.push_back(ref_mem[v.la]);
            if (v.ecg && v.cw) ref_mem[v.ca] = v.cd;
            if (v.elg && v.lw) ref_mem[v.la] = v.ld;
            if (v.ecg || v.elg) hold_a = ea;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem_init = 1'b1;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0; bus.l_lock = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        pend_c = 0; pend_l = 0; exp_crdata = '0; exp_lrdata = '0; hold_a = '0;
        @(posedge clk);
        #1;
        mem_init = 1'b0;

        // Reset with both requests high, then CPU write/read of addr 5.
        tbl.push_back(mk(1, 1,0,6'd1,32'h0,         1,0,6'd2,32'h0,0, 0,0));
        tbl.push_back(mk(0, 1,1,6'd5,32'hDEADBEEF,  0,0,6'd0,32'h0,0, 1,0));
        tbl.push_back(mk(0, 1,0,6'd5,32'h0,         0,0,6'd0,32'h0,0, 1,0));
        tbl.push_back(mk(0, 0,0,6'd0,32'h0,         0,0,6'd0,32'h0,0, 0,0));
        // Continuous contention: C,C,C,C,L repeating.
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(0, 1,0,6'd10,32'h0, 1,0,6'd3,32'h0,0, (k % 5) != 4, (k % 5) == 4));
        // Starved loader write to 9 beats a same-cycle CPU read of 9.
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 1,0,6'd9,32'h0, 1,1,6'd9,32'h22222222,0, 1,0));
        tbl.push_back(mk(0, 1,0,6'd9,32'h0, 1,1,6'd9,32'h22222222,0, 0,1));
        tbl.push_back(mk(0, 1,0,6'd9,32'h0, 0,0,6'd0,32'h0,0,        1,0));
        tbl.push_back(mk(0, 0,0,6'd0,32'h0, 0,0,6'd0,32'h0,0,        0,0));
        // Locked burst of four loader writes with the CPU waiting throughout.
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 1,0,6'd20,32'h0, 1,1,6'd20,32'hA0A0A0A0,1, 1,0));
        tbl.push_back(mk(0, 1,0,6'd20,32'h0, 1,1,6'd20,32'hA0A0A0A0,1, 0,1));
        tbl.push_back(mk(0, 1,0,6'd20,32'h0, 1,1,6'd21,32'hA1A1A1A1,1, 0,1));
        tbl.push_back(mk(0, 1,0,6'd20,32'h0, 1,1,6'd22,32'hA2A2A2A2,1, 0,1));
        tbl.push_back(mk(0, 1,0,6'd20,32'h0, 1,1,6'd23,32'hA3A3A3A3,0, 0,1));
        tbl.push_back(mk(0, 1,0,6'd20,32'h0, 0,0,6'd0,32'h0,0,         1,0));
        // Locked with no loader request: CPU still blocked, incl. the unlocking cycle.
        tbl.push_back(mk(0, 0,0,6'd0,32'h0,  1,1,6'd24,32'hBBBB0024,1, 0,1));
        tbl.push_back(mk(0, 1,0,6'd24,32'h0, 0,0,6'd0,32'h0,1,         0,0));
        tbl.push_back(mk(0, 1,0,6'd24,32'h0, 0,0,6'd0,32'h0,0,         0,0));
        tbl.push_back(mk(0, 1,0,6'd24,32'h0, 0,0,6'd0,32'h0,0,         1,0));
        tbl.push_back(mk(0, 0,0,6'd0,32'h0,  0,0,6'd0,32'h0,0,         0,0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Idle after a grant to addr 7: address held, no writes.
        step(mk(0, 0,0,6'd0,32'h0, 1,1,6'd7,32'h77777777,0, 0,1));
        for (int k = 0; k < 10; k++) begin
            step(mk(0, 0,0,6'd0,32'h0, 0,0,6'd0,32'h0,0, 0,0));
            chk("idle_hold_a", 32'(bus.mem_a), 32'd7);
        end
        step(mk(0, 0,0,6'd0,32'h0, 1,0,6'd7,32'h0,0, 0,1));
        step(mk(0, 0,0,6'd0,32'h0, 0,0,6'd0,32'h0,0, 0,0));

        // Reset one cycle after a locked loader read: rvalid suppressed, lock dropped.
        step(mk(0, 0,0,6'd0,32'h0,  1,1,6'd30,32'h30303030,1, 0,1));
        step(mk(0, 1,0,6'd5,32'h0,  1,0,6'd3,32'h0,1,          0,1));
        step(mk(1, 1,0,6'd5,32'h0,  1,0,6'd3,32'h0,1,          0,0));
        step(mk(0, 0,0,6'd0,32'h0,  0,0,6'd0,32'h0,0,          0,0));
        chk("post_rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        step(mk(0, 1,0,6'd5,32'h0,  0,0,6'd0,32'h0,0,          1,0));
        step(mk(0, 0,0,6'd0,32'h0,  0,0,6'd0,32'h0,0,          0,0));
        chk("final_c_rdata", bus.c_rdata, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 6, word address width; DATA_W, default 32, data width; MAX_WAIT, default 4, loader starvation limit in cycles (1..15).
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- c_req  in  1  CPU MEM-stage access request; held with c_we/c_addr/c_wdata stable until c_gnt.
- c_we  in  1  CPU write enable (1=write, 0=read).
- c_addr  in  ADDR_W  CPU word address.
- c_wdata  in  DATA_W  CPU write data.
- c_gnt  out  1  CPU access issued this cycle.
- c_rvalid  out  1  CPU read data valid, one-cycle pulse.
- c_rdata  out  DATA_W  CPU read data, held until next CPU read.
- l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader (debug/DMA) request, same rules as CPU.
- l_lock  in  1  loader burst lock; sampled with a granted l_req.
- l_gnt, l_rvalid, l_rdata  out  1/1/DATA_W  loader equivalents of c_gnt, c_rvalid, c_rdata.
- mem_we  out  1  to data memory write enable.
- mem_a  out  ADDR_W  to data memory address.
- mem_d  out  DATA_W  to data memory write data.
- mem_q  in  DATA_W  from data memory, valid late in the cycle mem_a is driven.

Function
REQ-003 SHALL issue at most one memory access per cycle; c_gnt and l_gnt SHALL never both be 1.
REQ-004 SHALL implement FSM states OPEN and LOCKED; reset state OPEN.
REQ-005 In OPEN, only c_req high -> grant CPU; only l_req high -> grant loader; both high -> grant CPU unless wait_cnt == MAX_WAIT, then grant loader.
REQ-006 wait_cnt (4 bits) SHALL increment each cycle l_req=1 and l_gnt=0, saturate at MAX_WAIT, and clear on any l_gnt.
REQ-007 OPEN -> LOCKED when loader is granted with l_lock=1; in LOCKED only loader is granted, and c_req waits regardless of wait_cnt.
REQ-008 LOCKED -> OPEN at the posedge of a cycle with l_lock=0; that cycle is still loader-only.
REQ-009 Grants SHALL be combinational in the issuing cycle; mem_we = gnt & we of the granted port; mem_a/mem_d from the granted port.
REQ-010 With no grant, mem_we=0, mem_a SHALL hold the last granted address, mem_d=0.
REQ-011 Read latency: granted read in cycle N -> mem_q registered into x_rdata at end of N; x_rvalid=1 for exactly cycle N+1.
REQ-012 Write issued in cycle N commits at end of N; a read of the same address by either port granted in N+1 or later SHALL return the new data.
REQ-013 x_rdata SHALL be unchanged by writes and by the other port's reads.
REQ-014 Back-to-back grants to the same port in consecutive cycles SHALL be allowed (one per cycle, full throughput).

Reset
REQ-015 While rst=1: c_gnt=l_gnt=0, mem_we=0, no memory write issued.
REQ-016 At posedge with rst=1: state=OPEN, wait_cnt=0, c_rvalid=l_rvalid=0, c_rdata=l_rdata=0, held mem_a=0.
REQ-017 Reset asserted in cycle N+1 after a granted read in N SHALL suppress x_rvalid in cycle N+2; a write issued in N is not undone.

Verification
REQ-018 CPU write 0xDEADBEEF to addr 5, then CPU read addr 5 -> c_gnt both cycles, c_rvalid one cycle later, c_rdata=0xDEADBEEF.
REQ-019 c_req and l_req held high continuously, MAX_WAIT=4 -> grants C,C,C,C,L repeating; l_gnt within 5 cycles of l_req; wait_cnt clears after each L.
REQ-020 Loader grant with l_lock=1 for 3 cycles, then l_lock=0, c_req high throughout -> 4 consecutive l_gnt, then c_gnt; c_gnt never during LOCKED.
REQ-021 Same cycle: CPU read addr 9 (memory 0x11111111), loader write 0x22222222 to addr 9, MAX_WAIT reached -> loader granted first; CPU read next cycle returns 0x22222222.
REQ-022 rst pulsed one cycle after granted loader read addr 3 -> l_rvalid stays 0, all outputs at reset values, mem_we=0 during rst.
REQ-023 No requests for 10 cycles after a grant to addr 7 -> mem_we=0, mem_a=7 throughout.
